// File: rtl/multi_policy_scheduler.sv
// Multi-policy grant scheduler: round-robin, fixed-priority and budgeted
// (per-queue grant quota refilled every replenish period) selection over
// NUM_QUEUES request queues, with a single outstanding transaction.
//
// Handshake: grant_valid is high for the whole GRANT state and grant_id is
// frozen there; the grant is accepted on a rising edge where grant_valid and
// grant_ready are both 1. done marks completion of the accepted transaction
// and may coincide with the accept; done outside GRANT/WAIT is ignored.
module multi_policy_scheduler #(
    parameter int NUM_QUEUES = 4,
    parameter int REG_W      = 32,
    parameter int PRIO_W     = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [1:0]                          mode,
    input  logic [NUM_QUEUES-1:0]               empty,
    input  logic [NUM_QUEUES-1:0][PRIO_W-1:0]   priorities,
    input  logic [NUM_QUEUES-1:0][REG_W-1:0]    budgets,
    input  logic [REG_W-1:0]                    period,
    output logic                                grant_valid,
    output logic [$clog2(NUM_QUEUES)-1:0]       grant_id,
    input  logic                                grant_ready,
    input  logic                                done,
    output logic [1:0]                          active_mode,
    output logic                                busy
);

    localparam int ID_W = $clog2(NUM_QUEUES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [1:0]             mode_q;
    logic [ID_W-1:0]        last_idx;
    logic [REG_W-1:0]       used [NUM_QUEUES];
    logic [REG_W-1:0]       period_cnt;
    logic [REG_W-1:0]       period_prev;

    logic [1:0]             sel_mode;
    logic [NUM_QUEUES-1:0]  budget_ok;
    logic [NUM_QUEUES-1:0]  fp_cand;
    logic [ID_W-1:0]        rr_cand;
    logic                   rr_found;
    logic [ID_W-1:0]        rr_idx;
    logic                   fp_found;
    logic [ID_W-1:0]        fp_idx;
    logic [PRIO_W-1:0]      fp_prio;
    logic                   sel_found;
    logic [ID_W-1:0]        sel_idx;
    logic                   accept;
    logic                   period_zero;
    logic                   period_changed;
    logic                   period_wrap;
    logic                   clear_used;

    assign accept         = (state_q == GRANT) && grant_ready;
    assign period_zero    = (period == '0);
    assign period_changed = (period != period_prev);
    assign period_wrap    = (period_cnt >= period - REG_W'(1));
    assign clear_used     = period_changed || period_wrap;

    assign grant_valid = (state_q == GRANT);
    assign busy        = (state_q != IDLE);
    assign active_mode = (mode_q == 2'd3) ? 2'd0 : mode_q;

    // A queue still has quota when enforcement is off or its count is below budget.
    always_comb begin
        budget_ok = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            budget_ok[i] = period_zero || (used[i] < budgets[i]);
        end
    end

    // Round-robin: first non-empty queue cyclically after the last accepted one.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            rr_cand = last_idx + ID_W'(k);
            if (!rr_found && !empty[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Highest-priority candidate, lowest index wins ties (strict compare).
    always_comb begin
        fp_cand  = (sel_mode == 2'd2) ? (~empty & budget_ok) : ~empty;
        fp_found = 1'b0;
        fp_idx   = '0;
        fp_prio  = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (fp_cand[i] && (!fp_found || (priorities[i] > fp_prio))) begin
                fp_found = 1'b1;
                fp_idx   = ID_W'(i);
                fp_prio  = priorities[i];
            end
        end
    end

    // Policy mux; the reserved encoding behaves as round-robin.
    always_comb begin
        sel_mode  = (mode == 2'd3) ? 2'd0 : mode;
        sel_found = (sel_mode == 2'd0) ? rr_found : fp_found;
        sel_idx   = (sel_mode == 2'd0) ? rr_idx : fp_idx;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found) state_d = GRANT;
            GRANT:   if (grant_ready) state_d = done ? IDLE : WAIT;
            WAIT:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant index, policy latch and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_id <= '0;
            mode_q   <= 2'd0;
            last_idx <= '1;
        end else begin
            if (state_q == IDLE) begin
                mode_q <= mode;
                if (sel_found) begin
                    grant_id <= sel_idx;
                end
            end
            if (accept) begin
                last_idx <= grant_id;
            end
        end
    end

    // Replenish period counter and per-queue saturating usage counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_cnt  <= '0;
            period_prev <= '0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                used[i] <= '0;
            end
        end else begin
            period_prev <= period;
            if (period_zero) begin
                period_cnt <= '0;
                for (int i = 0; i < NUM_QUEUES; i++) begin
                    used[i] <= '0;
                end
            end else begin
                period_cnt <= clear_used ? '0 : period_cnt + REG_W'(1);
                for (int i = 0; i < NUM_QUEUES; i++) begin
                    if (clear_used) begin
                        used[i] <= (accept && (grant_id == ID_W'(i))) ? REG_W'(1) : '0;
                    end else if (accept && (grant_id == ID_W'(i)) && (used[i] != '1)) begin
                        used[i] <= used[i] + REG_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_policy_scheduler.sv
// Bench for multi_policy_scheduler: transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_multi_policy_scheduler;

    localparam int N  = 4;
    localparam int RW = 32;
    localparam int PW = 4;

    // ---------------- clock / reset / stimulus signals ----------------
    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic [1:0]               mode = 2'd0;
    logic [N-1:0]             empty = '1;
    logic [N-1:0][PW-1:0]     priorities = '0;
    logic [N-1:0][RW-1:0]     budgets = '0;
    logic [RW-1:0]            period = '0;
    logic                     grant_ready = 1'b0;
    logic                     done = 1'b0;
    logic                     grant_valid;
    logic [$clog2(N)-1:0]     grant_id;
    logic [1:0]               active_mode;
    logic                     busy;

    always #5 clock = ~clock;

    multi_policy_scheduler #(.NUM_QUEUES(N), .REG_W(RW), .PRIO_W(PW)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .empty       (empty),
        .priorities  (priorities),
        .budgets     (budgets),
        .period      (period),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_ready (grant_ready),
        .done        (done),
        .active_mode (active_mode),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 no transaction, 1 grant offered, 2 waiting for completion
    int     m_phase;
    int     m_id;
    int     m_mode;
    int     m_last;
    longint m_used [N];
    longint m_pcnt;
    longint m_pprev;
    bit     m_valid = 1'b0;

    function automatic int pick_queue(input int pol);
        int best;
        bit ok;
        best = -1;
        if (pol == 0) begin
            for (int k = 1; k <= N; k++) begin
                if (!empty[(m_last + k) % N]) return (m_last + k) % N;
            end
            return -1;
        end
        for (int i = 0; i < N; i++) begin
            ok = !empty[i];
            if (pol == 2 && period != 0 && m_used[i] >= longint'(budgets[i])) ok = 1'b0;
            if (ok && (best < 0 || priorities[i] > priorities[best])) best = i;
        end
        return best;
    endfunction

    task automatic model_step();
        bit     acc;
        int     aid;
        int     sel;
        longint p;
        if (reset) begin
            m_phase = 0; m_id = 0; m_mode = 0; m_last = N - 1;
            m_pcnt = 0; m_pprev = 0;
            for (int i = 0; i < N; i++) m_used[i] = 0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        acc = (m_phase == 1) && grant_ready;
        aid = m_id;
        p   = longint'(period);
        sel = (m_phase == 0) ? pick_queue((mode == 2'd3) ? 0 : int'(mode)) : -1;
        // quota bookkeeping for this edge
        if (p == 0) begin
            m_pcnt = 0;
            for (int i = 0; i < N; i++) m_used[i] = 0;
        end else if (p != m_pprev || m_pcnt == p - 1) begin
            m_pcnt = 0;
            for (int i = 0; i < N; i++) m_used[i] = 0;
            if (acc) m_used[aid] = 1;
        end else begin
            m_pcnt = m_pcnt + 1;
            if (acc && m_used[aid] < 64'hFFFF_FFFF) m_used[aid] = m_used[aid] + 1;
        end
        m_pprev = p;
        // transaction phase
        case (m_phase)
            0: begin
                m_mode = int'(mode);
                if (sel >= 0) begin m_id = sel; m_phase = 1; end
            end
            1: if (grant_ready) begin m_last = m_id; m_phase = done ? 0 : 2; end
            default: if (done) m_phase = 0;
        endcase
    endtask

    always @(posedge clock) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (m_valid) begin
            check("grant_valid", grant_valid, (m_phase == 1));
            check("grant_id", grant_id, m_id);
            check("busy", busy, (m_phase != 0));
            check("active_mode", active_mode, (m_mode == 3) ? 0 : m_mode);
        end
    end

    // ---------------- scoreboard of accepted ids ----------------
    logic [1:0] exp_q [$];
    int         acc_ids [$];

    always @(negedge clock) begin
        if (!reset && grant_valid && grant_ready) acc_ids.push_back(int'(grant_id));
    end

    task automatic check_ids(input string name);
        check({name, "_count"}, acc_ids.size(), exp_q.size());
        while (exp_q.size() > 0 && acc_ids.size() > 0)
            check(name, acc_ids.pop_front(), exp_q.pop_front());
        exp_q.delete();
        acc_ids.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        acc_ids.delete();
    endtask

    task automatic set_budgets(input int b);
        for (int i = 0; i < N; i++) budgets[i] = RW'(b);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [N-1:0] toggles [5];
        toggles[0] = 4'b0001; toggles[1] = 4'b0110; toggles[2] = 4'b1111;
        toggles[3] = 4'b0000; toggles[4] = 4'b1010;

        // reset state
        step(2);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_active_mode", active_mode, 0);

        // round-robin streaming
        mode = 2'd0; empty = '0; grant_ready = 1'b1; done = 1'b1; period = '0;
        reset = 1'b0;
        step(1);
        check("rr_latency", grant_valid, 1);
        step(9);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        check_ids("rr_seq");

        // fixed priority with a tie between q1 and q2
        pulse_reset();
        mode = 2'd1;
        priorities = {4'd2, 4'd9, 4'd9, 4'd1};
        step(6);
        exp_q = '{2'd1, 2'd1, 2'd1};
        check_ids("fp_tie");
        empty = 4'b0010;
        step(4);
        exp_q = '{2'd2, 2'd2};
        check_ids("fp_next");

        // handshake hold while empty toggles, then delayed done
        mode = 2'd0; empty = '0; grant_ready = 1'b0; done = 1'b0;
        pulse_reset();
        step(1);
        for (int i = 0; i < 5; i++) begin
            empty = toggles[i];
            step(1);
            check("hs_valid_hold", grant_valid, 1);
            check("hs_id_hold", grant_id, 0);
        end
        grant_ready = 1'b1;
        step(1);
        grant_ready = 1'b0;
        empty = '1;
        for (int i = 0; i < 2; i++) begin
            check("hs_busy_wait", busy, 1);
            step(1);
        end
        check("hs_busy_wait", busy, 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("hs_idle", busy, 0);

        // policy switch requested mid-transaction
        pulse_reset();
        mode = 2'd0; empty = 4'b1110; grant_ready = 1'b1; done = 1'b0;
        step(2);
        empty = '1; mode = 2'd1; grant_ready = 1'b0;
        step(2);
        check("ms_wait_mode", active_mode, 0);
        check("ms_wait_busy", busy, 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("ms_first_idle", active_mode, 0);
        step(1);
        check("ms_latched", active_mode, 1);
        mode = 2'd3;
        step(2);
        check("ms_reserved", active_mode, 0);

        // budgeted: two grants per 100-cycle period for q0
        mode = 2'd2; set_budgets(2); period = 32'd100; empty = 4'b1110;
        grant_ready = 1'b1; done = 1'b1;
        pulse_reset();
        step(90);
        check("bud_first_period", acc_ids.size(), 2);
        acc_ids.delete();
        step(60);
        check("bud_after_wrap", acc_ids.size(), 2);

        // zero budget blocks the queue with no fallback
        set_budgets(0); empty = '0;
        pulse_reset();
        step(20);
        check("bud_zero_grants", acc_ids.size(), 0);
        check("bud_zero_idle", busy, 0);

        // period change mid-period clears usage; period 0 is unlimited
        set_budgets(2); empty = 4'b1110;
        pulse_reset();
        step(20);
        check("pc_before", acc_ids.size(), 2);
        acc_ids.delete();
        period = 32'd50;
        step(10);
        check("pc_after_change", acc_ids.size(), 2);
        acc_ids.delete();
        period = '0;
        step(20);
        check("pc_unlimited", acc_ids.size(), 10);

        // reset while a grant is pending
        period = 32'd100; grant_ready = 1'b0; done = 1'b0;
        step(3);
        check("rg_in_grant", grant_valid, 1);
        reset = 1'b1;
        step(1);
        check("rg_aborted", grant_valid, 0);
        reset = 1'b0; empty = '1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
